instr_fetch_unit: RTL and testbench

- Initiator side of the instruction-memory read interface: owns the 64-bit PC, drives the byte address into the combinational instruction ROM, and captures the returned 32-bit word.
- Buffers fetched {pc, instruction} pairs in a small FIFO toward decode, using a valid/ready handshake.
- Handles branch redirects, flushes, and address faults (out-of-bounds or misaligned PC) for the pipeline's IF stage.

---
 rtl/instr_fetch_unit.sv | 119 +++++++++++
 tb/tb_instr_fetch_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads the combinational instruction
// ROM, and queues {pc, instruction} pairs toward decode through a small FIFO.
// Handles branch redirects and stops on out-of-bounds or misaligned PCs.
module instr_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'd0,
    parameter int unsigned MEM_SIZE = 1024,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fetch_en,
    output logic [63:0] imem_address,
    input  logic [31:0] imem_instruction,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    output logic        fault,
    output logic [63:0] fault_pc,
    output logic [31:0] fetch_count
);

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    state_t      state;
    logic [63:0] pc;

    // Storage is sized for the largest legal DEPTH; pointers wrap at DEPTH.
    logic [63:0] fifo_pc    [4];
    logic [31:0] fifo_instr [4];
    logic [1:0]  rd_ptr;
    logic [1:0]  wr_ptr;
    logic [2:0]  count;

    logic [64:0] pc_end;
    logic        pc_bad;
    logic        pop;
    logic        push_ok;
    logic        push;

    function automatic logic [1:0] ptr_next(input logic [1:0] p);
        return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    // Last byte of the word is computed one bit wider so it cannot wrap past zero.
    assign pc_end  = {1'b0, pc} + 65'd3;
    assign pc_bad  = (pc[1:0] != 2'b00) || (pc_end >= 65'(MEM_SIZE));

    assign imem_address = pc;
    assign out_valid    = (count != 3'd0);
    assign out_pc       = out_valid ? fifo_pc[rd_ptr]    : 64'd0;
    assign out_instr    = out_valid ? fifo_instr[rd_ptr] : 32'd0;

    // A full FIFO that drains this cycle can still accept the next word.
    assign pop     = out_valid && out_ready;
    assign push_ok = (count < 3'(DEPTH)) || pop;
    assign push    = !redirect_valid && (state == RUN) && fetch_en && !pc_bad && push_ok;

    // PC sequencing and fault FSM; redirect overrides everything, FAULT holds until redirect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc       <= RESET_PC;
            state    <= RUN;
            fault    <= 1'b0;
            fault_pc <= 64'd0;
        end else if (redirect_valid) begin
            pc    <= redirect_target;
            state <= RUN;
            fault <= 1'b0;
        end else if (state == RUN) begin
            if (fetch_en) begin
                if (pc_bad) begin
                    state    <= FAULT;
                    fault    <= 1'b1;
                    fault_pc <= pc;
                end else if (push_ok) begin
                    pc <= pc + 64'd4;
                end
            end
        end
    end

    // FIFO pointers, occupancy and accepted-instruction counter; redirect flushes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr      <= 2'd0;
            wr_ptr      <= 2'd0;
            count       <= 3'd0;
            fetch_count <= 32'd0;
        end else if (redirect_valid) begin
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (pop) begin
                rd_ptr      <= ptr_next(rd_ptr);
                fetch_count <= fetch_count + 32'd1;
            end
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            count <= count + {2'b00, push} - {2'b00, pop};
        end
    end

    // FIFO payload; outputs are gated by occupancy, so the data needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]    <= pc;
            fifo_instr[wr_ptr] <= imem_instruction;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a scoreboard of expected
// {pc, instruction} deliveries, checked on every decode handshake.
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic        fetch_en;
    logic [63:0] imem_address;
    logic [31:0] imem_instruction;
    logic        redirect_valid;
    logic [63:0] redirect_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        fault;
    logic [63:0] fault_pc;
    logic [31:0] fetch_count;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t exp_q[$];
    int   vectors;
    int   miscompares;

    instr_fetch_unit #(
        .RESET_PC (64'd0),
        .MEM_SIZE (1024),
        .DEPTH    (2)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .fetch_en         (fetch_en),
        .imem_address     (imem_address),
        .imem_instruction (imem_instruction),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_instr        (out_instr),
        .out_pc           (out_pc),
        .fault            (fault),
        .fault_pc         (fault_pc),
        .fetch_count      (fetch_count)
    );

    // Instruction ROM contents: a distinct word for every address.
    function automatic logic [31:0] rom_word(input logic [63:0] a);
        return {a[15:0] ^ 16'hBEEF, ~a[15:0]};
    endfunction

    assign imem_instruction = rom_word(imem_address);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h, required %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [63:0] a);
        exp_q.push_back('{pc: a, instr: rom_word(a)});
    endtask

    // One clock: score a handshake that will occur at this edge, then step past it.
    task automatic tick();
        ent_t e;
        if (out_valid && out_ready && !redirect_valid) begin
            vectors++;
            assert (exp_q.size() != 0) else begin
                miscompares++;
                $error("FAIL sb_unexpected: got delivery pc %h, required none", out_pc);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_pc", out_pc, e.pc);
                chk("sb_instr", {32'd0, out_instr}, {32'd0, e.instr});
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors         = 0;
        miscompares     = 0;
        reset_n         = 1'b0;
        fetch_en        = 1'b0;
        out_ready       = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 64'd0;
        @(posedge clk);
        #1;

        // Reset state
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_instr", {32'd0, out_instr}, 64'd0);
        chk("rst_pc_out", out_pc, 64'd0);
        chk("rst_fault", {63'd0, fault}, 64'd0);
        chk("rst_fault_pc", fault_pc, 64'd0);
        chk("rst_count", {32'd0, fetch_count}, 64'd0);
        chk("rst_addr", imem_address, 64'd0);

        // Streaming: (0,A),(4,B),(8,C) on consecutive cycles
        reset_n   = 1'b1;
        fetch_en  = 1'b1;
        out_ready = 1'b1;
        push_exp(64'h0);
        push_exp(64'h4);
        push_exp(64'h8);
        chk("s1_valid_pre", {63'd0, out_valid}, 64'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("s1_valid", {63'd0, out_valid}, 64'd1);
            tick();
        end
        chk("s1_count", {32'd0, fetch_count}, 64'd3);
        chk("s1_drained", 64'(exp_q.size()), 64'd0);

        // Restart from reset for the backpressure run
        fetch_en = 1'b0;
        reset_n  = 1'b0;
        #2;
        reset_n = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;

        // Backpressure: 5 stalled cycles, PC parks at 8 with 2 queued
        fetch_en  = 1'b1;
        out_ready = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("s2_hold_pc", out_pc, 64'h0);
            chk("s2_hold_instr", {32'd0, out_instr}, {32'd0, rom_word(64'h0)});
            tick();
        end
        chk("s2_pc_parked", imem_address, 64'h8);
        chk("s2_valid", {63'd0, out_valid}, 64'd1);
        out_ready = 1'b1;
        push_exp(64'h0);
        push_exp(64'h4);
        push_exp(64'h8);
        push_exp(64'hC);
        for (int i = 0; i < 4; i++) tick();
        chk("s2_drained", 64'(exp_q.size()), 64'd0);
        chk("s2_count", {32'd0, fetch_count}, 64'd4);

        // Redirect to 0x40 with 2 queued and a same-cycle accept
        chk("s3_valid_pre", {63'd0, out_valid}, 64'd1);
        redirect_valid  = 1'b1;
        redirect_target = 64'h40;
        tick();
        redirect_valid = 1'b0;
        chk("s3_flushed", {63'd0, out_valid}, 64'd0);
        chk("s3_count", {32'd0, fetch_count}, 64'd4);
        chk("s3_addr", imem_address, 64'h40);
        push_exp(64'h40);
        tick();
        tick();
        chk("s3_drained", 64'(exp_q.size()), 64'd0);

        // Bounds fault: word at 0x3FC delivered, then stop at 0x400
        redirect_valid  = 1'b1;
        redirect_target = 64'h3FC;
        tick();
        redirect_valid = 1'b0;
        push_exp(64'h3FC);
        tick();
        tick();
        chk("s4_fault", {63'd0, fault}, 64'd1);
        chk("s4_fault_pc", fault_pc, 64'h400);
        chk("s4_drained", 64'(exp_q.size()), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("s4_no_push", {63'd0, out_valid}, 64'd0);
            chk("s4_pc_hold", imem_address, 64'h400);
        end
        redirect_valid  = 1'b1;
        redirect_target = 64'h0;
        tick();
        redirect_valid = 1'b0;
        fetch_en       = 1'b0;
        chk("s4_cleared", {63'd0, fault}, 64'd0);
        chk("s4_count", {32'd0, fetch_count}, 64'd6);

        // Alignment fault at 0x6: never delivers anything
        fetch_en        = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 64'h6;
        tick();
        redirect_valid = 1'b0;
        chk("s5_fault_pre", {63'd0, fault}, 64'd0);
        tick();
        chk("s5_fault", {63'd0, fault}, 64'd1);
        chk("s5_fault_pc", fault_pc, 64'h6);
        for (int i = 0; i < 3; i++) begin
            chk("s5_no_valid", {63'd0, out_valid}, 64'd0);
            tick();
        end
        chk("s5_pc_hold", imem_address, 64'h6);

        // Async reset between edges with 2 entries queued
        out_ready       = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 64'h100;
        tick();
        redirect_valid = 1'b0;
        tick();
        tick();
        chk("s6_valid_pre", {63'd0, out_valid}, 64'd1);
        chk("s6_head_pc", out_pc, 64'h100);
        chk("s6_addr_pre", imem_address, 64'h108);
        #2;
        reset_n = 1'b0;
        #1;
        chk("s6_valid", {63'd0, out_valid}, 64'd0);
        chk("s6_fault", {63'd0, fault}, 64'd0);
        chk("s6_fault_pc", fault_pc, 64'd0);
        chk("s6_count", {32'd0, fetch_count}, 64'd0);
        chk("s6_addr", imem_address, 64'd0);
        chk("s6_out_pc", out_pc, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
